// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, LOCKED)
//   XFER_CNT_W  : width of the accepted-beat counter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int XFER_CNT_W = 16;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Rotating-priority search: returns the first set bit of req, starting at
// ptr and wrapping from N_REQ-1 back to 0.
// Ports:
//   req   [N_REQ-1:0] request vector
//   ptr   [ID_W-1:0]  highest-priority position
//   found             at least one request is set
//   idx   [ID_W-1:0]  index of the selected request (0 when none)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  // One extra bit so ptr + offset can exceed N_REQ-1 before folding back.
  logic [ID_W:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter merging N_REQ valid/ready requesters onto one FIFO
// write port. Grant is combinational; the round-robin pointer advances past
// each accepted winner. A full FIFO stalls everything.
// Optional feature (macro FIFO_ARB_PKT_LOCK_EN): once a requester's first
// non-last beat is accepted, the grant stays with it until its i_last beat.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_valid/i_data/i_last  per-requester beat, data slice k*WIDTH +: WIDTH
//   o_ready         one-hot accept toward the winner
//   o_wen/o_wdata   FIFO write strobe and data, i_full FIFO full flag
//   o_wid           index of the requester driving o_wdata
//   o_xfer_cnt      saturating count of accepted beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_valid,
  input  logic [N_REQ*WIDTH-1:0]   i_data,
  input  logic [N_REQ-1:0]         i_last,
  output logic [N_REQ-1:0]         o_ready,
  output logic [WIDTH-1:0]         o_wdata,
  output logic                     o_wen,
  input  logic                     i_full,
  output logic [$clog2(N_REQ)-1:0] o_wid,
  output logic [XFER_CNT_W-1:0]    o_xfer_cnt
);

  localparam int ID_W = $clog2(N_REQ);

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] w);
    return (w == ID_W'(N_REQ-1)) ? '0 : w + 1'b1;
  endfunction

  function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            is_locked;
  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic            accept;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (i_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // While locked the owner keeps the grant even with i_valid low, so a
  // bubble in its packet cannot let another requester interleave.
  assign is_locked = (state_q == LOCKED);
  assign win_found = i_rst_n && (is_locked || pick_found);
  assign win_idx   = is_locked ? owner_q : pick_idx;

  always_comb begin
    o_ready = '0;
    o_wdata = '0;
    o_wid   = '0;
    if (win_found) begin
      o_wid = win_idx;
      if (!i_full) begin
        o_ready[win_idx] = 1'b1;
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (win_idx == ID_W'(k)) begin
          o_wdata = i_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign accept     = |(i_valid & o_ready);
  assign o_wen      = accept;
  assign o_xfer_cnt = xfer_cnt_q;

  // Next-state: nothing moves without an accepted beat, which also covers
  // the full-FIFO hold.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    xfer_cnt_d = accept ? sat_inc(xfer_cnt_q) : xfer_cnt_q;
    if (accept) begin
`ifdef FIFO_ARB_PKT_LOCK_EN
      case (state_q)
        IDLE: begin
          if (i_last[win_idx]) begin
            rr_ptr_d = ptr_after(win_idx);
          end else begin
            state_d = LOCKED;
            owner_d = win_idx;
          end
        end
        LOCKED: begin
          if (i_last[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_after(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
`else
      rr_ptr_d = ptr_after(win_idx);
`endif
    end
  end

`ifndef FIFO_ARB_PKT_LOCK_EN
  logic unused_last;
  assign unused_last = ^i_last;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule : fifo_wr_arbiter
